stats_reg_bank: RTL and testbench
=================================

STATS_REG_BANK -- requirements
Module: stats_reg_bank

Interface
REQ-001 SHALL have parameter addr_width, default 7, the register address width in bits.
REQ-002 SHALL have parameter data_width, default 32, the data bus width; only 32 is supported.
REQ-003 SHALL have clk  in  1  the single clock; one clock, reset is synchronous and active-high.
REQ-004 SHALL have rst  in  1  synchronous active-high reset.
REQ-005 SHALL have write_req  in  1  write request from the AXI4-Lite slave, held until write_ready.
REQ-006 SHALL have write_addr  in  addr_width  write byte address.
REQ-007 SHALL have write_data  in  data_width  write data, from s_axi_wdata.
REQ-008 SHALL have write_strb  in  data_width/8  byte enables, from s_axi_wstrb.
REQ-009 SHALL have write_ready  out  1  one-cycle write completion.
REQ-010 SHALL have write_response  out  1  0 = OKAY, 1 = SLVERR; valid with write_ready.
REQ-011 SHALL have read_req  in  1  read request, held until read_ready.
REQ-012 SHALL have read_addr  in  addr_width  read byte address, from s_axi_araddr.
REQ-013 SHALL have read_ready  out  1  one-cycle read completion.
REQ-014 SHALL have read_response  out  1  0 = OKAY, 1 = SLVERR; valid with read_ready.
REQ-015 SHALL have read_value  out  data_width  read data; valid with read_ready.
REQ-016 SHALL have event_pulse  in  1  counted event, one per cycle while high.

Function
REQ-017 Register map (word-aligned): 0x00 CFG RW (bit0 enable, bit1 clear, self-clearing); 0x04 SCRATCH RW; 0x08 COUNT_LO RO; 0x0C COUNT_HI RO (shadow); 0x10 STATUS (bit0 overflow, write-1-to-clear).
REQ-018 Read and write channels SHALL each run an independent FSM with states IDLE and RESP.
REQ-019 Transitions: IDLE->RESP on req; RESP->IDLE unconditionally; ready = 1 only in RESP.
REQ-020 A req still high in RESP SHALL be treated as the same transaction and not re-executed.
REQ-021 Latency SHALL be exactly one cycle from the first req cycle to the ready cycle.
REQ-022 Writes SHALL commit at the IDLE->RESP edge and honour write_strb per byte.
REQ-023 Writes to RO registers or unmapped addresses SHALL change no state and return SLVERR.
REQ-024 Reads of unmapped addresses SHALL return SLVERR with read_value 0.
REQ-025 read_value SHALL be registered and SHALL hold its value outside RESP.
REQ-026 The 64-bit counter SHALL increment by 1 on each cycle where event_pulse is high and enable is 1.
REQ-027 Overflow: counter SHALL wrap from all-ones to 0 and set STATUS.overflow.
REQ-028 Reading COUNT_LO SHALL return the live low word and latch the live high word into COUNT_HI in the same cycle.
REQ-029 Writing clear = 1 SHALL zero the counter and the shadow on the next cycle; CFG bit1 SHALL always read 0.
REQ-030 A clear coincident with an increment SHALL win.
REQ-031 A COUNT_LO read coincident with a clear commit SHALL return the pre-clear value.
REQ-032 An overflow coincident with a STATUS W1C write SHALL leave overflow set.
REQ-033 A read and a write in the same cycle SHALL both proceed; the read SHALL return the pre-write value.

Reset
REQ-034 Reset SHALL drive write_ready, read_ready, write_response, read_response and read_value to 0.
REQ-035 Reset SHALL set both FSMs to IDLE and zero CFG, SCRATCH, the counter, the shadow and STATUS.
REQ-036 Reset asserted during RESP SHALL abort the transaction; no ready SHALL follow.

Structure
REQ-037 Package stats_reg_bank_pkg SHALL hold the register offsets, the CFG/STATUS bit positions, and the OKAY/SLVERR constants.
REQ-038 Sub-module stats_counter64 SHALL implement the counter, clear, overflow flag and shadow latch.

Verification
REQ-039 Write 0x04 = 0xDEADBEEF with strb 0b0101, then read 0x04 -> 0x00AD00EF, OKAY, ready exactly 1 cycle after req.
REQ-040 Set enable = 1, drive 10 event pulses, read 0x08 then 0x0C -> 10 and 0.
REQ-041 Preload counter at 0xFFFFFFFF_FFFFFFFF, apply 1 event -> counter 0, STATUS = 1; write STATUS 1 -> STATUS = 0.
REQ-042 Write 0x08, then read 0x20 -> both SLVERR; read_value 0; no state change.
REQ-043 Write clear together with event_pulse, then read 0x08 -> 0; CFG reads bit1 = 0.
REQ-044 Assert rst during read RESP -> read_ready 0 next cycle; all registers read 0 afterwards.

Source files
------------

// File: rtl/stats_reg_bank_pkg.sv
// Shared constants for the event statistics register bank: register offsets,
// bit positions, response codes and channel FSM encodings.
package stats_reg_bank_pkg;

    localparam logic [7:0] REG_CFG      = 8'h00;
    localparam logic [7:0] REG_SCRATCH  = 8'h04;
    localparam logic [7:0] REG_COUNT_LO = 8'h08;
    localparam logic [7:0] REG_COUNT_HI = 8'h0C;
    localparam logic [7:0] REG_STATUS   = 8'h10;

    localparam int CFG_ENABLE_BIT = 0;
    localparam int CFG_CLEAR_BIT  = 1;
    localparam int STATUS_OVF_BIT = 0;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CFG,
        SEL_SCRATCH,
        SEL_COUNT_LO,
        SEL_COUNT_HI,
        SEL_STATUS
    } reg_sel_e;

    function automatic logic sel_is_writable(input reg_sel_e sel);
        return (sel == SEL_CFG) || (sel == SEL_SCRATCH) || (sel == SEL_STATUS);
    endfunction

endpackage

// File: rtl/stats_counter64.sv
// 64-bit event counter with synchronous clear, sticky W1C overflow flag and a
// high-word shadow captured whenever software samples the low word.
module stats_counter64
    import stats_reg_bank_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        event_i,
    input  logic        enable_i,
    input  logic        clear_i,
    input  logic        latch_hi_i,
    input  logic        ovf_clr_i,
    output logic [63:0] count_o,
    output logic [31:0] shadow_hi_o,
    output logic        overflow_o
);

    logic [63:0] count_q, count_d;
    logic [31:0] shadow_q, shadow_d;
    logic        ovf_q, ovf_d;
    logic        ovf_set;

    always_comb begin
        count_d  = count_q;
        shadow_d = shadow_q;
        ovf_set  = 1'b0;
        // Clear beats both a coincident increment and a coincident shadow latch.
        if (clear_i) begin
            count_d  = '0;
            shadow_d = '0;
        end else begin
            if (event_i && enable_i) begin
                count_d = count_q + 64'd1;
                ovf_set = &count_q;
            end
            if (latch_hi_i) begin
                shadow_d = count_q[63:32];
            end
        end
        // A new overflow outranks a software clear in the same cycle.
        ovf_d = (ovf_q & ~ovf_clr_i) | ovf_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            shadow_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign count_o     = count_q;
    assign shadow_hi_o = shadow_q;
    assign overflow_o  = ovf_q;

endmodule

// File: rtl/stats_reg_bank.sv
// Register bank behind an AXI4-Lite-style req/ready handshake, exposing the
// 64-bit event counter with configuration, scratch and status registers.
//
// state   | meaning (one FSM per read and write channel)
// IDLE    | waiting for req; access executes on the IDLE->RESP edge
// RESP    | ready and response presented for exactly one cycle
module stats_reg_bank
    import stats_reg_bank_pkg::*;
#(
    parameter int addr_width = 7,
    parameter int data_width = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      write_req,
    input  logic [addr_width-1:0]     write_addr,
    input  logic [data_width-1:0]     write_data,
    input  logic [data_width/8-1:0]   write_strb,
    output logic                      write_ready,
    output logic                      write_response,
    input  logic                      read_req,
    input  logic [addr_width-1:0]     read_addr,
    output logic                      read_ready,
    output logic                      read_response,
    output logic [data_width-1:0]     read_value,
    input  logic                      event_pulse
);

    localparam int AW_EXT = (addr_width > 8) ? addr_width : 8;

    function automatic reg_sel_e decode(input logic [AW_EXT-1:0] a);
        case (a)
            AW_EXT'(REG_CFG):      return SEL_CFG;
            AW_EXT'(REG_SCRATCH):  return SEL_SCRATCH;
            AW_EXT'(REG_COUNT_LO): return SEL_COUNT_LO;
            AW_EXT'(REG_COUNT_HI): return SEL_COUNT_HI;
            AW_EXT'(REG_STATUS):   return SEL_STATUS;
            default:               return SEL_NONE;
        endcase
    endfunction

    logic [0:0]            wr_state_q, wr_state_d;
    logic [0:0]            rd_state_q, rd_state_d;
    logic                  write_response_q, write_response_d;
    logic                  read_response_q, read_response_d;
    logic [data_width-1:0] read_value_q, read_value_d;
    logic                  cfg_enable_q, cfg_enable_d;
    logic [data_width-1:0] scratch_q, scratch_d;

    reg_sel_e              wr_sel, rd_sel;
    logic                  wr_fire, wr_ok, rd_fire;
    logic                  cnt_clear, cnt_latch_hi, ovf_clr;
    logic [data_width-1:0] rd_data;
    logic [63:0]           count;
    logic [31:0]           shadow_hi;
    logic                  overflow;

    // Write channel: commit happens only on the IDLE cycle, so a req still
    // held during RESP is the same transaction and is not replayed.
    always_comb begin
        wr_sel           = decode(AW_EXT'(write_addr));
        wr_fire          = (wr_state_q == ST_IDLE) && write_req;
        wr_ok            = wr_fire && sel_is_writable(wr_sel);
        wr_state_d       = (wr_state_q == ST_IDLE && write_req) ? ST_RESP : ST_IDLE;
        write_response_d = write_response_q;
        if (wr_fire) begin
            write_response_d = sel_is_writable(wr_sel) ? RESP_OKAY : RESP_SLVERR;
        end
        scratch_d    = scratch_q;
        cfg_enable_d = cfg_enable_q;
        cnt_clear    = 1'b0;
        ovf_clr      = 1'b0;
        if (wr_ok) begin
            for (int b = 0; b < data_width/8; b++) begin
                if (write_strb[b] && wr_sel == SEL_SCRATCH) begin
                    scratch_d[8*b +: 8] = write_data[8*b +: 8];
                end
            end
            if (write_strb[0] && wr_sel == SEL_CFG) begin
                cfg_enable_d = write_data[CFG_ENABLE_BIT];
                cnt_clear    = write_data[CFG_CLEAR_BIT];
            end
            if (write_strb[0] && wr_sel == SEL_STATUS) begin
                ovf_clr = write_data[STATUS_OVF_BIT];
            end
        end
    end

    always_comb begin
        rd_sel          = decode(AW_EXT'(read_addr));
        rd_fire         = (rd_state_q == ST_IDLE) && read_req;
        rd_state_d      = (rd_state_q == ST_IDLE && read_req) ? ST_RESP : ST_IDLE;
        cnt_latch_hi    = rd_fire && (rd_sel == SEL_COUNT_LO);
        rd_data         = '0;
        case (rd_sel)
            SEL_CFG:      rd_data = data_width'(cfg_enable_q);
            SEL_SCRATCH:  rd_data = scratch_q;
            SEL_COUNT_LO: rd_data = data_width'(count[31:0]);
            SEL_COUNT_HI: rd_data = data_width'(shadow_hi);
            SEL_STATUS:   rd_data = data_width'(overflow);
            default:      rd_data = '0;
        endcase
        read_value_d    = rd_fire ? rd_data : read_value_q;
        read_response_d = read_response_q;
        if (rd_fire) begin
            read_response_d = (rd_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q       <= ST_IDLE;
            rd_state_q       <= ST_IDLE;
            write_response_q <= RESP_OKAY;
            read_response_q  <= RESP_OKAY;
            read_value_q     <= '0;
            cfg_enable_q     <= 1'b0;
            scratch_q        <= '0;
        end else begin
            wr_state_q       <= wr_state_d;
            rd_state_q       <= rd_state_d;
            write_response_q <= write_response_d;
            read_response_q  <= read_response_d;
            read_value_q     <= read_value_d;
            cfg_enable_q     <= cfg_enable_d;
            scratch_q        <= scratch_d;
        end
    end

    stats_counter64 u_counter (
        .clk         (clk),
        .rst         (rst),
        .event_i     (event_pulse),
        .enable_i    (cfg_enable_q),
        .clear_i     (cnt_clear),
        .latch_hi_i  (cnt_latch_hi),
        .ovf_clr_i   (ovf_clr),
        .count_o     (count),
        .shadow_hi_o (shadow_hi),
        .overflow_o  (overflow)
    );

    assign write_ready    = (wr_state_q == ST_RESP);
    assign read_ready     = (rd_state_q == ST_RESP);
    assign write_response = write_response_q;
    assign read_response  = read_response_q;
    assign read_value     = read_value_q;

endmodule

// File: tb/tb_stats_reg_bank.sv
// Directed bench for stats_reg_bank: handshake latency, byte strobes, counter,
// shadow latch, overflow W1C, error responses, clear and reset abort.
module tb_stats_reg_bank;

    logic        clk;
    logic        rst;
    logic        write_req;
    logic [6:0]  write_addr;
    logic [31:0] write_data;
    logic [3:0]  write_strb;
    logic        write_ready;
    logic        write_response;
    logic        read_req;
    logic [6:0]  read_addr;
    logic        read_ready;
    logic        read_response;
    logic [31:0] read_value;
    logic        event_pulse;

    int checks = 0;
    int errors = 0;

    stats_reg_bank #(.addr_width(7), .data_width(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .write_req      (write_req),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .write_strb     (write_strb),
        .write_ready    (write_ready),
        .write_response (write_response),
        .read_req       (read_req),
        .read_addr      (read_addr),
        .read_ready     (read_ready),
        .read_response  (read_response),
        .read_value     (read_value),
        .event_pulse    (event_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic resp);
        int n;
        @(negedge clk);
        write_req = 1'b1; write_addr = a; write_data = d; write_strb = s;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!write_ready && n < 4);
        chk("wr_latency", 64'(n), 64'd1);
        resp = write_response;
        @(negedge clk);
        write_req = 1'b0;
    endtask

    task automatic rd(input logic [6:0] a, output logic [31:0] v, output logic resp);
        int n;
        @(negedge clk);
        read_req = 1'b1; read_addr = a;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!read_ready && n < 4);
        chk("rd_latency", 64'(n), 64'd1);
        v    = read_value;
        resp = read_response;
        @(negedge clk);
        read_req = 1'b0;
    endtask

    // Held across one edge with events idle so the flop itself takes the value.
    task automatic preload(input logic [63:0] v);
        @(negedge clk);
        force dut.u_counter.count_q = v;
        @(posedge clk); #1;
        release dut.u_counter.count_q;
    endtask

    task automatic pulses(input int n);
        @(negedge clk);
        event_pulse = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        event_pulse = 1'b0;
    endtask

    logic [31:0] v;
    logic        r;

    initial begin
        rst = 1'b1; write_req = 1'b0; write_addr = '0; write_data = '0; write_strb = '0;
        read_req = 1'b0; read_addr = '0; event_pulse = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_write_ready", 64'(write_ready), 64'd0);
        chk("rst_read_ready", 64'(read_ready), 64'd0);
        chk("rst_write_resp", 64'(write_response), 64'd0);
        chk("rst_read_resp", 64'(read_response), 64'd0);
        chk("rst_read_value", 64'(read_value), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Byte strobes 0101 keep bytes 0 and 2 only.
        wr(7'h04, 32'hDEADBEEF, 4'b0101, r);
        chk("scratch_wr_resp", 64'(r), 64'd0);
        rd(7'h04, v, r);
        chk("scratch_rd_value", 64'(v), 64'h00AD00EF);
        chk("scratch_rd_resp", 64'(r), 64'd0);
        @(posedge clk); #1;
        chk("rd_ready_one_cycle", 64'(read_ready), 64'd0);
        chk("rd_value_held", 64'(read_value), 64'h00AD00EF);

        wr(7'h00, 32'h1, 4'hF, r);
        pulses(10);
        rd(7'h08, v, r);
        chk("count_lo_10", 64'(v), 64'd10);
        rd(7'h0C, v, r);
        chk("count_hi_0", 64'(v), 64'd0);

        // Clear coincident with an event: clear wins.
        @(negedge clk);
        write_req = 1'b1; write_addr = 7'h00; write_data = 32'h3; write_strb = 4'hF;
        event_pulse = 1'b1;
        @(posedge clk); #1;
        chk("clear_wr_ready", 64'(write_ready), 64'd1);
        @(negedge clk);
        write_req = 1'b0; event_pulse = 1'b0;
        rd(7'h08, v, r);
        chk("count_after_clear", 64'(v), 64'd0);
        rd(7'h00, v, r);
        chk("cfg_clear_reads_0", 64'(v), 64'd1);

        // Shadow carries the high word sampled with the low word.
        preload(64'h12345678_9ABCDEF0);
        rd(7'h08, v, r);
        chk("shadow_lo", 64'(v), 64'h9ABCDEF0);
        rd(7'h0C, v, r);
        chk("shadow_hi", 64'(v), 64'h12345678);

        preload(64'hFFFFFFFF_FFFFFFFF);
        pulses(1);
        rd(7'h08, v, r);
        chk("wrap_lo", 64'(v), 64'd0);
        rd(7'h0C, v, r);
        chk("wrap_hi", 64'(v), 64'd0);
        rd(7'h10, v, r);
        chk("ovf_set", 64'(v), 64'd1);
        wr(7'h10, 32'h1, 4'h1, r);
        chk("status_w1c_resp", 64'(r), 64'd0);
        rd(7'h10, v, r);
        chk("ovf_cleared", 64'(v), 64'd0);

        // New overflow in the same cycle as a W1C keeps the flag set.
        preload(64'hFFFFFFFF_FFFFFFFF);
        @(negedge clk);
        write_req = 1'b1; write_addr = 7'h10; write_data = 32'h1; write_strb = 4'h1;
        event_pulse = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        write_req = 1'b0; event_pulse = 1'b0;
        rd(7'h10, v, r);
        chk("ovf_beats_w1c", 64'(v), 64'd1);

        // Simultaneous read and write: read sees the old scratch value.
        @(negedge clk);
        write_req = 1'b1; write_addr = 7'h04; write_data = 32'h11111111; write_strb = 4'hF;
        read_req = 1'b1; read_addr = 7'h04;
        @(posedge clk); #1;
        chk("rw_wr_ready", 64'(write_ready), 64'd1);
        chk("rw_rd_ready", 64'(read_ready), 64'd1);
        chk("rw_rd_old", 64'(read_value), 64'h00AD00EF);
        @(negedge clk);
        write_req = 1'b0; read_req = 1'b0;
        rd(7'h04, v, r);
        chk("rw_rd_new", 64'(v), 64'h11111111);

        pulses(3);
        wr(7'h08, 32'hFFFFFFFF, 4'hF, r);
        chk("ro_wr_slverr", 64'(r), 64'd1);
        wr(7'h20, 32'hFFFFFFFF, 4'hF, r);
        chk("unmapped_wr_slverr", 64'(r), 64'd1);
        rd(7'h08, v, r);
        chk("ro_count_unchanged", 64'(v), 64'd3);
        chk("ro_rd_okay", 64'(r), 64'd0);
        rd(7'h20, v, r);
        chk("unmapped_rd_value", 64'(v), 64'd0);
        chk("unmapped_rd_slverr", 64'(r), 64'd1);
        rd(7'h04, v, r);
        chk("scratch_unchanged", 64'(v), 64'h11111111);

        // Reset during read RESP aborts it and zeroes everything.
        @(negedge clk);
        read_req = 1'b1; read_addr = 7'h04;
        @(posedge clk); #1;
        chk("abort_rd_ready", 64'(read_ready), 64'd1);
        @(negedge clk);
        read_req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_no_ready", 64'(read_ready), 64'd0);
        chk("abort_value_zero", 64'(read_value), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        rd(7'h00, v, r); chk("post_rst_cfg", 64'(v), 64'd0);
        rd(7'h04, v, r); chk("post_rst_scratch", 64'(v), 64'd0);
        rd(7'h08, v, r); chk("post_rst_lo", 64'(v), 64'd0);
        rd(7'h0C, v, r); chk("post_rst_hi", 64'(v), 64'd0);
        rd(7'h10, v, r); chk("post_rst_status", 64'(v), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
